// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the core's memory path.
//   lsu_state_t   - LSU FSM state encoding (plain logic vector + constants)
//   F3_*          - RV32I load/store funct3 width codes
//   lsu_op_error  - illegal-width / misaligned-address detection
package core_pkg;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t LSU_IDLE   = 2'd0;
  localparam lsu_state_t LSU_REQ    = 2'd1;
  localparam lsu_state_t LSU_WAIT_R = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Returns 1 for an unknown width code or an address that is not
  // naturally aligned to the access width.
  function automatic logic lsu_op_error(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] lane);
    logic err;
    err = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_SB:   err = 1'b0;
        F3_SH:   err = lane[0];
        F3_SW:   err = (lane != 2'b00);
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: err = 1'b0;
        F3_LH, F3_LHU: err = lane[0];
        F3_LW:         err = (lane != 2'b00);
        default:       err = 1'b1;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/halfword out of a bus read word
// and sign- or zero-extends it according to the load funct3.
//   rdata  [31:0]  read data word from the bus
//   addr   [1:0]   byte offset of the load
//   funct3 [2:0]   load width/sign code
//   result [31:0]  extended load value
module load_align
  import core_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = rdata[7:0];
    case (addr)
      2'd0: lane_byte = rdata[7:0];
      2'd1: lane_byte = rdata[15:8];
      2'd2: lane_byte = rdata[23:16];
      2'd3: lane_byte = rdata[31:24];
      default: lane_byte = rdata[7:0];
    endcase
  end

  // addr[0] is guaranteed 0 for halfwords, so only addr[1] selects the half.
  assign lane_half = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = {{24{lane_byte[7]}}, lane_byte};
      F3_LH:   result = {{16{lane_half[15]}}, lane_half};
      F3_LW:   result = rdata;
      F3_LBU:  result = {24'd0, lane_byte};
      F3_LHU:  result = {16'd0, lane_half};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between execute and a simple
// request/grant + rvalid memory bus.
//   clk, rst             core clock, async active-high reset
//   ex_*                 op from execute (valid/ready handshake)
//   mem_*                bus request, strobes, lane-shifted store data,
//                        grant and read return
//   wb_valid/wb_rd/wb_data  one-cycle load writeback
//   misalign_err         one-cycle pulse for illegal/misaligned ops
//
// state      | meaning
// -----------+-----------------------------------------------
// LSU_IDLE   | ready for a new op (ex_ready high)
// LSU_REQ    | mem_req held with stable addr/strobes until mem_gnt
// LSU_WAIT_R | load granted, waiting for mem_rvalid
module lsu
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err
);

  lsu_state_t  state;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [4:0]  r_rd;

  logic        op_err;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [31:0] ld_result;

  assign ex_ready = (state == LSU_IDLE);
  assign op_err   = lsu_op_error(ex_is_store, ex_funct3, ex_addr[1:0]);

  always_comb begin
    st_strb = 4'b1111;
    st_data = ex_wdata;
    case (ex_funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << ex_addr[1:0];
        st_data = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << ex_addr[1:0];
        st_data = {2{ex_wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = ex_wdata;
      end
    endcase
  end

  load_align u_load_align (
    .rdata  (mem_rdata),
    .addr   (r_lane),
    .funct3 (r_funct3),
    .result (ld_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LSU_IDLE;
      r_is_store   <= 1'b0;
      r_funct3     <= 3'd0;
      r_lane       <= 2'd0;
      r_rd         <= 5'd0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wstrb    <= 4'd0;
      mem_wdata    <= 32'd0;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (ex_valid) begin
            r_is_store <= ex_is_store;
            r_funct3   <= ex_funct3;
            r_lane     <= ex_addr[1:0];
            r_rd       <= ex_rd;
            if (op_err) begin
              misalign_err <= 1'b1;
            end else begin
              state     <= LSU_REQ;
              mem_req   <= 1'b1;
              mem_we    <= ex_is_store;
              mem_addr  <= {ex_addr[31:2], 2'b00};
              mem_wstrb <= ex_is_store ? st_strb : 4'd0;
              mem_wdata <= ex_is_store ? st_data : 32'd0;
            end
          end
        end
        LSU_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= r_is_store ? LSU_IDLE : LSU_WAIT_R;
          end
        end
        LSU_WAIT_R: begin
          if (mem_rvalid) begin
            wb_valid <= 1'b1;
            wb_rd    <= r_rd;
            wb_data  <= ld_result;
            state    <= LSU_IDLE;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed stimulus with a scoreboard. The driver pushes the
// hand-computed bus / writeback / error events it expects; a monitor on
// the falling edge pops and compares whenever the DUT presents one.
module tb_lsu;
  import core_pkg::*;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err;

  lsu dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_is_store  (ex_is_store),
    .ex_funct3    (ex_funct3),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .ex_rd        (ex_rd),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_BUS = 1;
  localparam int K_WB  = 2;
  localparam int K_ERR = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic pop_check(input int kind);
    exp_t e;
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected event: got kind %0d expected none at %0t", kind, $time);
      return;
    end
    e = sb_q.pop_front();
    check("event kind", kind, e.kind);
    if (e.kind != kind) return;
    case (kind)
      K_BUS: begin
        check("mem_addr", mem_addr, e.addr);
        check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
        check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e.strb});
        if (e.chk_wdata) check("mem_wdata", mem_wdata, e.wdata);
      end
      K_WB: begin
        check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        check("wb_data", wb_data, e.data);
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && mem_gnt) pop_check(K_BUS);
      if (wb_valid)           pop_check(K_WB);
      if (misalign_err)       pop_check(K_ERR);
    end
  end

  // One op: wait for ready, push expected events, handshake, then play the
  // bus side (grant after gdly cycles, read data the cycle after grant).
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input int gdly,
                       input logic [31:0] rdata, input logic err, input logic [3:0] xstrb,
                       input logic [31:0] xwdata, input logic [31:0] xwb);
    exp_t e;
    int n;
    n = 0;
    while (!ex_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ex_ready) begin
      check("ex_ready wait timeout", {31'd0, ex_ready}, 32'd1);
      return;
    end
    e = '{kind: K_ERR, addr: 32'd0, we: 1'b0, strb: 4'd0, wdata: 32'd0,
          chk_wdata: 1'b0, rd: 5'd0, data: 32'd0};
    if (err) begin
      sb_q.push_back(e);
    end else begin
      e.kind = K_BUS;
      e.addr = addr & 32'hFFFF_FFFC;
      e.we = st;
      e.strb = xstrb;
      e.wdata = xwdata;
      e.chk_wdata = st;
      sb_q.push_back(e);
      if (!st) begin
        e.kind = K_WB;
        e.rd = rd;
        e.data = xwb;
        sb_q.push_back(e);
      end
    end
    ex_is_store = st;
    ex_funct3 = f3;
    ex_addr = addr;
    ex_wdata = wdata;
    ex_rd = rd;
    ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    if (err) begin
      check("no mem_req on error", {31'd0, mem_req}, 32'd0);
      check("ready after error", {31'd0, ex_ready}, 32'd1);
      return;
    end
    for (int i = 0; i < gdly; i++) begin
      check("held mem_req", {31'd0, mem_req}, 32'd1);
      check("held mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
      check("held mem_wstrb", {28'd0, mem_wstrb}, {28'd0, xstrb});
      @(posedge clk); #1;
    end
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    if (st) begin
      check("ready after store", {31'd0, ex_ready}, 32'd1);
      return;
    end
    mem_rvalid = 1'b1;
    mem_rdata = rdata;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("wb_valid pulse", {31'd0, wb_valid}, 32'd1);
    check("ready with wb_valid", {31'd0, ex_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    ex_valid = 1'b0; ex_is_store = 1'b0; ex_funct3 = 3'd0;
    ex_addr = 32'd0; ex_wdata = 32'd0; ex_rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ex_ready", {31'd0, ex_ready}, 32'd1);
    check("reset mem_req", {31'd0, mem_req}, 32'd0);
    check("reset mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset wb_valid", {31'd0, wb_valid}, 32'd0);
    check("reset wb_data", wb_data, 32'd0);
    check("reset misalign_err", {31'd0, misalign_err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    //    st    f3     addr          wdata          rd  gdly rdata          err   strb     xwdata         xwb
    issue(1'b1, F3_SW, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 0, 32'd0,         1'b0, 4'b1111, 32'hDEAD_BEEF, 32'd0);
    issue(1'b1, F3_SB, 32'h0000_0103, 32'h0000_00A5, 5'd0, 0, 32'd0,         1'b0, 4'b1000, 32'hA5A5_A5A5, 32'd0);
    issue(1'b1, F3_SH, 32'h0000_0102, 32'h1234_BEEF, 5'd0, 1, 32'd0,         1'b0, 4'b1100, 32'hBEEF_BEEF, 32'd0);
    issue(1'b0, F3_LB, 32'h0000_0102, 32'd0,         5'd5, 0, 32'h0080_FF00, 1'b0, 4'b0000, 32'd0,         32'hFFFF_FF80);
    issue(1'b0, F3_LBU,32'h0000_0102, 32'd0,         5'd6, 0, 32'h0080_FF00, 1'b0, 4'b0000, 32'd0,         32'h0000_0080);
    issue(1'b0, F3_LB, 32'h0000_0101, 32'd0,         5'd8, 0, 32'h0080_FF00, 1'b0, 4'b0000, 32'd0,         32'hFFFF_FFFF);
    issue(1'b0, F3_LH, 32'h0000_0201, 32'd0,         5'd3, 0, 32'd0,         1'b1, 4'b0000, 32'd0,         32'd0);
    issue(1'b0, F3_LW, 32'h0000_0300, 32'd0,         5'd7, 3, 32'h1234_5678, 1'b0, 4'b0000, 32'd0,         32'h1234_5678);
    issue(1'b0, F3_LH, 32'h0000_0202, 32'd0,         5'd0, 0, 32'h8001_0000, 1'b0, 4'b0000, 32'd0,         32'hFFFF_8001);
    issue(1'b0, F3_LHU,32'h0000_0202, 32'd0,         5'd4, 0, 32'h8001_0000, 1'b0, 4'b0000, 32'd0,         32'h0000_8001);
    issue(1'b1, F3_SW, 32'h0000_0101, 32'h1111_1111, 5'd0, 0, 32'd0,         1'b1, 4'b0000, 32'd0,         32'd0);
    issue(1'b0, 3'b011,32'h0000_0100, 32'd0,         5'd2, 0, 32'd0,         1'b1, 4'b0000, 32'd0,         32'd0);
    issue(1'b1, 3'b100,32'h0000_0100, 32'd0,         5'd0, 0, 32'd0,         1'b1, 4'b0000, 32'd0,         32'd0);

    // Stray rvalid and gnt while idle must not produce any event.
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    check("no wb on idle rvalid", {31'd0, wb_valid}, 32'd0);

    // Reset while waiting for read data: transaction is dropped.
    e = '{kind: K_BUS, addr: 32'h0000_0400, we: 1'b0, strb: 4'd0, wdata: 32'd0,
          chk_wdata: 1'b0, rd: 5'd0, data: 32'd0};
    sb_q.push_back(e);
    ex_is_store = 1'b0; ex_funct3 = F3_LW; ex_addr = 32'h0000_0400; ex_rd = 5'd9;
    ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    check("in WAIT_R before reset", {31'd0, ex_ready}, 32'd0);
    rst = 1'b1;
    #2;
    check("ready during reset", {31'd0, ex_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("no wb after reset", {31'd0, wb_valid}, 32'd0);
      @(posedge clk); #1;
    end
    check("idle after reset", {31'd0, ex_ready}, 32'd1);
    check("no mem_req after reset", {31'd0, mem_req}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL expose these ports, clock and reset first:
  clk  in  1  single core clock; all state updates on rising edge.
  rst  in  1  asynchronous, active-high reset.
  ex_valid  in  1  execute stage presents a memory op.
  ex_ready  out  1  LSU can accept an op this cycle.
  ex_is_store  in  1  1 = store, 0 = load.
  ex_funct3  in  3  RV32I load/store width/sign code.
  ex_addr  in  32  effective address (ALU result).
  ex_wdata  in  32  store data (rs2).
  ex_rd  in  5  load destination register.
  mem_req  out  1  bus request.
  mem_we  out  1  bus write enable.
  mem_addr  out  32  word address, bits [1:0] = 0.
  mem_wstrb  out  4  byte write strobes.
  mem_wdata  out  32  lane-shifted store data.
  mem_gnt  in  1  bus accepts request this cycle.
  mem_rvalid  in  1  read data valid.
  mem_rdata  in  32  read data word.
  wb_valid  out  1  one-cycle load writeback pulse.
  wb_rd  out  5  writeback register index.
  wb_data  out  32  extended load result.
  misalign_err  out  1  one-cycle error pulse.

Function
REQ-002 The FSM SHALL have states IDLE, REQ, WAIT_R; ex_ready = (state == IDLE).
REQ-003 On ex_valid && ex_ready, the LSU SHALL capture is_store, funct3, addr, wdata and rd into internal registers.
REQ-004 Legal funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW.
REQ-005 A captured op SHALL be an error if funct3 is illegal, halfword with addr[0]=1, or word with addr[1:0]≠00.
REQ-006 On an error, the LSU SHALL pulse misalign_err the cycle after acceptance, issue no bus request, remain in IDLE, and not assert wb_valid.
REQ-007 On a legal op, the next state SHALL be REQ; mem_req=1 with registered mem_addr={addr[31:2],2'b00}, mem_we=is_store, held stable until mem_gnt.
REQ-008 Store strobes SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111. For loads, mem_wstrb SHALL be 0.
REQ-009 Store mem_wdata SHALL be the replicated low byte (SB) or low halfword (SH), or the full word (SW).
REQ-010 In REQ with mem_gnt: a store SHALL return to IDLE; a load SHALL go to WAIT_R.
REQ-011 In WAIT_R with mem_rvalid, the LSU SHALL register the extracted byte/halfword/word, sign- or zero-extend it per funct3, pulse wb_valid for the next cycle with wb_rd, and return to IDLE.
REQ-012 Loads to rd=0 SHALL complete normally, including the wb_valid pulse with wb_rd=0.
REQ-013 mem_rvalid outside WAIT_R and mem_gnt outside REQ SHALL be ignored.
REQ-014 Minimum latency: store accept→gnt 1 cycle; load accept→wb_valid 3 cycles with same-cycle gnt and rvalid.
REQ-015 Back-to-back ops SHALL be accepted in the same cycle the FSM reaches IDLE, i.e. the cycle wb_valid pulses.

Reset
REQ-016 On rst, the state SHALL go to IDLE and mem_req, mem_we, mem_wstrb, wb_valid and misalign_err SHALL be 0; mem_addr, mem_wdata, wb_rd and wb_data SHALL be 0.
REQ-017 rst asserted mid-transaction SHALL abandon the transaction with no writeback; a later rvalid SHALL be ignored.

Structure
REQ-018 The shared core_pkg SHALL hold lsu_state_t and the funct3 width constants (LB..LHU, SB..SW).
REQ-019 Load lane extraction and extension SHALL live in one combinational sub-module, load_align (inputs rdata, addr[1:0], funct3; output 32-bit result).

Verification
REQ-020 The bench SHALL cover these scenarios:
  Reset, then SW addr 0x100, wdata 0xDEADBEEF, gnt same cycle → mem_addr 0x100, wstrb 1111, wdata 0xDEADBEEF, ex_ready high next cycle.
  SB addr 0x103, wdata 0x000000A5 → wstrb 1000, wdata 0xA5A5A5A5.
  LB addr 0x102, rdata 0x0080FF00 → wb_data 0xFFFFFF80.
  LBU at the same address → wb_data 0x00000080.
  LH addr 0x201 → misalign_err pulse, no mem_req.
  LW with gnt delayed 3 cycles → mem_req, mem_addr and wstrb held stable throughout.
  rst during WAIT_R → no wb_valid, state IDLE.
